// File: rtl/mcp3008_responder_if.sv
// SPI pin bundle between an MCP3008-style master and the responder.
// The master drives clock, select and command data; the responder drives dout and its enable.
interface mcp3008_responder_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output sclk, output cs_n, output din, input dout, input dout_oe);
  modport slave  (input sclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp3008_responder.sv
// MCP3008 responder: oversamples the SPI pins on clk, decodes start/SGL/D2..D0 and
// shifts a snapshot of the selected channel (or clamped difference) back on dout.
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mcp3008_responder_if.slave    spi,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic                  conv_valid,
  output logic [2:0]            conv_ch,
  output logic                  conv_sgl,
  output logic [DATA_W-1:0]     conv_result,
  output logic                  abort
);

  localparam logic [2:0] ST_ARM        = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_CMD        = 3'd3;
  localparam logic [2:0] ST_OUT        = 3'd4;

  localparam logic [4:0] F_LAST_ABORT = 5'd11;
  localparam logic [4:0] F_SAT        = 5'd21;

  function automatic logic [DATA_W-1:0] chan(input logic [8*DATA_W-1:0] bus,
                                             input logic [2:0] idx);
    chan = bus[idx*DATA_W +: DATA_W];
  endfunction

  // Differential mode clamps at zero; the extra MSB keeps the compare from wrapping.
  function automatic logic [DATA_W-1:0] conv_calc(input logic [8*DATA_W-1:0] bus,
                                                  input logic sgl,
                                                  input logic [2:0] d);
    logic [DATA_W:0]   a;
    logic [DATA_W:0]   b;
    logic [DATA_W-1:0] diff;
    a    = {1'b0, chan(bus, d)};
    b    = {1'b0, chan(bus, {d[2:1], ~d[0]})};
    diff = a[DATA_W-1:0] - b[DATA_W-1:0];
    if (sgl) begin
      conv_calc = a[DATA_W-1:0];
    end else if (a > b) begin
      conv_calc = diff;
    end else begin
      conv_calc = '0;
    end
  endfunction

  // f=2..11 sends B9..B0, f=12..20 sends B1..B9; 4-bit index math is exact in both ranges.
  function automatic logic frame_bit(input logic [DATA_W-1:0] s, input logic [4:0] f);
    logic [3:0] idx;
    idx       = 4'd0;
    frame_bit = 1'b0;
    if (f >= 5'd2 && f <= 5'd11) begin
      idx       = 4'd11 - f[3:0];
      frame_bit = s[idx];
    end else if (f >= 5'd12 && f <= 5'd20) begin
      idx       = f[3:0] - 4'd11;
      frame_bit = s[idx];
    end else begin
      frame_bit = 1'b0;
    end
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, din_s;
  logic                   sclk_rise_s, sclk_fall_s, cs_rise_s;

  // cs_n synchronizer clears to 0 so ARM only leaves once the real pin is seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi.din};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign din_s       = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [4:0]        f_q, f_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic              dout_q, dout_d, oe_q, oe_d;
  logic              cv_q, cv_d, abort_q, abort_d, sgl_q, sgl_d;
  logic [2:0]        ch_q, ch_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [4:0]        f_next_s;
  logic [2:0]        d_dec_s;

  assign f_next_s = (f_q == F_SAT) ? F_SAT : f_q + 5'd1;
  assign d_dec_s  = {cmd_q[1:0], din_s};

  // Frame sequencing; a cs_n rise always wins over an sclk edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    f_d     = f_q;
    snap_d  = snap_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    cv_d    = 1'b0;
    abort_d = 1'b0;
    ch_d    = ch_q;
    sgl_d   = sgl_q;
    res_d   = res_q;
    case (state_q)
      ST_ARM: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_IDLE: begin
        dout_d = 1'b0;
        oe_d   = 1'b0;
        if (!cs_s) begin
          state_d = ST_WAIT_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_START: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (sclk_rise_s && din_s) begin
          state_d = ST_CMD;
          cnt_d   = 2'd0;
          cmd_d   = 3'd0;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_CMD: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (sclk_rise_s) begin
          if (cnt_q == 2'd3) begin
            snap_d  = conv_calc(ch_data, cmd_q[2], d_dec_s);
            res_d   = conv_calc(ch_data, cmd_q[2], d_dec_s);
            ch_d    = d_dec_s;
            sgl_d   = cmd_q[2];
            cv_d    = 1'b1;
            f_d     = 5'd0;
            state_d = ST_OUT;
          end else begin
            cmd_d = {cmd_q[1:0], din_s};
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_OUT: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          dout_d  = 1'b0;
          oe_d    = 1'b0;
          abort_d = (f_q < F_LAST_ABORT);
        end else if (sclk_fall_s) begin
          f_d    = f_next_s;
          oe_d   = 1'b1;
          dout_d = frame_bit(snap_q, f_next_s);
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ARM;
        dout_d  = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARM;
      cnt_q   <= 2'd0;
      cmd_q   <= 3'd0;
      f_q     <= 5'd0;
      snap_q  <= '0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
      cv_q    <= 1'b0;
      abort_q <= 1'b0;
      ch_q    <= 3'd0;
      sgl_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      f_q     <= f_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cv_q    <= cv_d;
      abort_q <= abort_d;
      ch_q    <= ch_d;
      sgl_q   <= sgl_d;
      res_q   <= res_d;
    end
  end

  assign spi.dout    = dout_q;
  assign spi.dout_oe = oe_q;
  assign conv_valid  = cv_q;
  assign conv_ch     = ch_q;
  assign conv_sgl    = sgl_q;
  assign conv_result = res_q;
  assign abort       = abort_q;

endmodule
